// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : md_ctrl
// Purpose  : Multiply/divide sequencer for the execute stage. Computes the
//            result at accept time, stages it, holds busy for a fixed
//            latency and commits to HI/LO with a one-cycle done pulse.
// Revision : 1.0  initial release
// ============================================================================
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cancel_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   stage_hi_q, stage_hi_d;
  logic [31:0]   stage_lo_q, stage_lo_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          done_q, done_d;

  logic          accept;
  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [31:0]   div_q;
  logic [31:0]   div_r;
  logic [31:0]   divu_q;
  logic [31:0]   divu_r;

  // Both products are formed at 64 bits; sign-extending the operands makes the
  // low 64 bits of the unsigned product equal to the two's-complement product.
  assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Division results, including the divide-by-zero and signed overflow cases
  // whose architectural values are fixed rather than left to the operator.
  always_comb begin
    div_q  = 32'd0;
    div_r  = 32'd0;
    divu_q = 32'd0;
    divu_r = 32'd0;
    if (b_i == 32'd0) begin
      div_q  = 32'hFFFF_FFFF;
      div_r  = a_i;
      divu_q = 32'hFFFF_FFFF;
      divu_r = a_i;
    end else begin
      divu_q = a_i / b_i;
      divu_r = a_i % b_i;
      if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
        div_q = 32'h8000_0000;
        div_r = 32'd0;
      end else begin
        div_q = $signed(a_i) / $signed(b_i);
        div_r = $signed(a_i) % $signed(b_i);
      end
    end
  end

  // A flush in the same cycle kills the request; requests while busy are dropped.
  assign accept = start_i && !cancel_i && (state_q == IDLE);

  // Next-state: load the latency counter on accept, count down in RUN and
  // commit the staged result on the 1->0 transition.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    stage_hi_d = stage_hi_q;
    stage_lo_d = stage_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op_i)
            OP_MULT: begin
              stage_hi_d = prod_s[63:32];
              stage_lo_d = prod_s[31:0];
              count_d    = CW'(MULT_CYCLES);
              state_d    = RUN;
            end
            OP_MULTU: begin
              stage_hi_d = prod_u[63:32];
              stage_lo_d = prod_u[31:0];
              count_d    = CW'(MULT_CYCLES);
              state_d    = RUN;
            end
            OP_DIV: begin
              stage_hi_d = div_r;
              stage_lo_d = div_q;
              count_d    = CW'(DIV_CYCLES);
              state_d    = RUN;
            end
            OP_DIVU: begin
              stage_hi_d = divu_r;
              stage_lo_d = divu_q;
              count_d    = CW'(DIV_CYCLES);
              state_d    = RUN;
            end
            OP_MTHI: hi_d = a_i;
            OP_MTLO: lo_d = a_i;
            default: ;
          endcase
        end
      end
      RUN: begin
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          hi_d    = stage_hi_q;
          lo_d    = stage_lo_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, staged result and architectural HI/LO registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      count_q    <= '0;
      stage_hi_q <= 32'd0;
      stage_lo_q <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      stage_hi_q <= stage_hi_d;
      stage_lo_q <= stage_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_ctrl
// Purpose  : Directed self-checking bench for md_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_md_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        cancel_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int nvec = 0;
  int nerr = 0;
  int bc;
  int dc;

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .cancel_i (cancel_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one start request for a single edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cancel);
    start_i  = 1'b1;
    op_i     = op;
    a_i      = a;
    b_i      = b;
    cancel_i = cancel;
    tick();
    start_i  = 1'b0;
    cancel_i = 1'b0;
  endtask

  // Count cycles that read busy=1, bounded so a stuck busy cannot hang the run.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy_o === 1'b1 && n < 50) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; start_i = 1'b0; op_i = 3'd0; a_i = 32'd0; b_i = 32'd0; cancel_i = 1'b0;
    tick(); tick();
    reset_i = 1'b0;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);

    // MULT -2 * 3 = -6
    issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_hold_hi", hi_o, 32'd0);
    check("mult_hold_lo", lo_o, 32'd0);
    wait_idle(bc);
    check("mult_busy_cycles", bc, 32'd5);
    check("mult_done", {31'd0, done_o}, 32'd1);
    check("mult_hi", hi_o, 32'hFFFF_FFFF);
    check("mult_lo", lo_o, 32'hFFFF_FFFA);
    dc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_o === 1'b1) dc++;
    end
    check("mult_done_once", dc, 32'd0);

    // MULTU max * max
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_idle(bc);
    check("multu_busy_cycles", bc, 32'd5);
    check("multu_hi", hi_o, 32'hFFFF_FFFE);
    check("multu_lo", lo_o, 32'h0000_0001);

    // DIV -7 / 2 -> q=-3, r=-1
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(bc);
    check("div_busy_cycles", bc, 32'd10);
    check("div_done", {31'd0, done_o}, 32'd1);
    check("div_lo", lo_o, 32'hFFFF_FFFD);
    check("div_hi", hi_o, 32'hFFFF_FFFF);

    // DIV overflow
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(bc);
    check("divovf_lo", lo_o, 32'h8000_0000);
    check("divovf_hi", hi_o, 32'd0);

    // DIVU by zero
    issue(3'd3, 32'd5, 32'd0, 1'b0);
    wait_idle(bc);
    check("divz_lo", lo_o, 32'hFFFF_FFFF);
    check("divz_hi", hi_o, 32'd5);
    tick();

    // Start with cancel in the same cycle: fully ignored
    issue(3'd0, 32'd2, 32'd3, 1'b1);
    check("cancel_busy", {31'd0, busy_o}, 32'd0);
    check("cancel_done", {31'd0, done_o}, 32'd0);
    check("cancel_hi", hi_o, 32'd5);
    check("cancel_lo", lo_o, 32'hFFFF_FFFF);
    tick();
    check("cancel_done2", {31'd0, done_o}, 32'd0);

    // DIV 100 / 7 with cancel pulsed mid-run: still commits q=14, r=2
    issue(3'd2, 32'd100, 32'd7, 1'b0);
    tick(); tick();
    cancel_i = 1'b1;
    tick();
    cancel_i = 1'b0;
    wait_idle(bc);
    check("divcan_rest_cycles", bc, 32'd7);
    check("divcan_done", {31'd0, done_o}, 32'd1);
    check("divcan_lo", lo_o, 32'd14);
    check("divcan_hi", hi_o, 32'd2);
    tick();

    // Second start while busy is ignored
    issue(3'd1, 32'd3, 32'd4, 1'b0);
    issue(3'd3, 32'd100, 32'd7, 1'b0);
    wait_idle(bc);
    check("b2b_rest_cycles", bc, 32'd4);
    check("b2b_lo", lo_o, 32'd12);
    check("b2b_hi", hi_o, 32'd0);

    // MTLO accepted in the done cycle (first cycle with busy=0)
    issue(3'd5, 32'h1234_5678, 32'd0, 1'b0);
    check("mtlo_lo", lo_o, 32'h1234_5678);
    check("mtlo_hi", hi_o, 32'd0);
    check("mtlo_busy", {31'd0, busy_o}, 32'd0);
    check("mtlo_done", {31'd0, done_o}, 32'd0);
    tick();
    check("mtlo_busy2", {31'd0, busy_o}, 32'd0);

    // MTHI then reserved op
    issue(3'd4, 32'hCAFE_F00D, 32'd0, 1'b0);
    check("mthi_hi", hi_o, 32'hCAFE_F00D);
    issue(3'd6, 32'h1111_1111, 32'd2, 1'b0);
    check("rsv_busy", {31'd0, busy_o}, 32'd0);
    check("rsv_hi", hi_o, 32'hCAFE_F00D);
    check("rsv_lo", lo_o, 32'h1234_5678);

    // Reset mid-RUN
    issue(3'd0, 32'd7, 32'd9, 1'b0);
    tick();
    check("rstrun_busy_pre", {31'd0, busy_o}, 32'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("rstrun_busy", {31'd0, busy_o}, 32'd0);
    check("rstrun_hi", hi_o, 32'd0);
    check("rstrun_lo", lo_o, 32'd0);
    dc = 0;
    for (int i = 0; i < 8; i++) begin
      if (done_o === 1'b1 || busy_o === 1'b1) dc++;
      tick();
    end
    check("rstrun_quiet", dc, 32'd0);
    check("rstrun_lo_end", lo_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide sequencer for the 5-stage pipeline's execute stage. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation per start pulse. It holds a busy counter for the configured latency and commits results to the HI/LO registers at completion. Its busy/done outputs feed the hazard logic, which stalls any later multiply/divide instruction in decode while an operation is in flight. An interrupt-flush input suppresses a start that arrives in the same cycle.

## Interface
- MULT_CYCLES, 5, busy duration for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy duration for DIV/DIVU (≥1)

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  operation request from E stage, sampled on clk
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (no-op)
- a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
- b  in  32  rt operand (divisor / multiplier)
- cancel  in  1  interrupt flush (IntReq); suppresses a start in the same cycle
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse after HI/LO commit
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- Reset: busy=0, done=0, hi=0, lo=0, counter=0, staged result cleared.
- Accepted start = start & !cancel & !busy. A start while busy is ignored; hazard logic must prevent it. A start with cancel is fully ignored, with no state change.
- States: IDLE (count==0), RUN (count!=0). busy = (count != 0), registered.
- MULT/MULTU accepted: 64-bit product of a×b is computed and staged. MULT treats operands as two's complement, MULTU as unsigned. Counter loads MULT_CYCLES. Staged HI = product[63:32], LO = product[31:0].
- DIV/DIVU accepted: quotient is staged to LO and remainder to HI. Counter loads DIV_CYCLES.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIV overflow (a=0x80000000, b=0xFFFFFFFF): LO=0x80000000, HI=0.
  - Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=a.
- MTHI/MTLO accepted: hi or lo is written with a at the same edge. busy stays 0 and no done pulse is issued.
- Reserved op: no effect.
- RUN: counter decrements every edge. On the edge where the counter goes 1→0, staged HI/LO are written to hi/lo and done is set for exactly one cycle.
- cancel while already busy has no effect; an op that was accepted earlier always commits.
- Reset during RUN: returns to IDLE, hi/lo=0, no done pulse.
- hi/lo stay at their old values for the entire RUN period. mfhi/mflo consumers are stalled by hazard logic while busy.

## Timing
- Start accepted at edge T:
  - busy=1 from T+ through the cycle before edge T+LAT.
  - hi/lo hold new values after edge T+LAT.
  - busy=0 and done=1 in the cycle after edge T+LAT.
  - done returns to 0 after edge T+LAT+1.
- LAT is MULT_CYCLES or DIV_CYCLES. Exactly LAT cycles read busy=1.
- Back-to-back: a new start is accepted at edge T+LAT+1, the first cycle with busy=0. No gap cycle beyond that is required.
- MTHI/MTLO: hi/lo are updated after one edge, with zero busy cycles.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Reset, then MULT a=0xFFFFFFFE(−2), b=3 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- DIV a=−7 (0xFFFFFFF9), b=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=5.
- start=1 with cancel=1 (MULT 2×3) → busy stays 0, hi/lo unchanged, no done.
- DIV started, then cancel pulsed at cycle 3 → commit still occurs at cycle 10.
- Second start during busy → ignored.
- MTLO a=0x12345678 → lo=0x12345678 next cycle, busy never asserts.
- Reset asserted mid-RUN → busy=0, hi=lo=0, no done.
